// File: rtl/sd_cmd_arbiter.sv
// Two-requester arbiter in front of the SD command master, with a command watchdog.
// Define SD_CMD_ARB_RR_EN for round-robin tie-breaking; the default build is fixed priority (A wins).
module sd_cmd_arbiter #(
  parameter logic [15:0] WD_MAX = 16'd4095
) (
  input  logic        CLK_PAD_IO,
  input  logic        RST_PAD_I,
  input  logic        a_req,
  input  logic [31:0] a_arg,
  input  logic [13:0] a_cmd,
  input  logic        b_req,
  input  logic [31:0] b_arg,
  input  logic [13:0] b_cmd,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic [31:0] resp_o,
  output logic [4:0]  err_o,
  output logic        new_cmd_o,
  output logic [31:0] arg_o,
  output logic [13:0] cmd_set_o,
  output logic        int_rst_o,
  input  logic        cicmd_i,
  input  logic        cc_i,
  input  logic        ei_i,
  input  logic [4:0]  err_int_i,
  input  logic [31:0] resp_i
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  logic [1:0]  state_r;
  logic [15:0] wd_r;
  logic        win_b_s;
  logic        fin_s;
  logic        wd_hit_s;
  logic        tmo_s;

`ifdef SD_CMD_ARB_RR_EN
  // ptr_r set means B is favoured on the next tie (A was granted last)
  logic        ptr_r;
  assign win_b_s = b_req & (~a_req | ptr_r);
`else
  assign win_b_s = b_req & ~a_req;
`endif

  assign fin_s    = cc_i | ei_i;
  assign wd_hit_s = ({1'b0, wd_r} + 17'd1) >= {1'b0, WD_MAX};
  // A real cicmd/completion on the same edge beats the watchdog
  assign tmo_s    = wd_hit_s & (((state_r == ST_ISSUE) & ~cicmd_i) |
                                ((state_r == ST_WAIT) & ~fin_s));

  // Arbitration FSM, command issue handshake, completion capture and watchdog
  always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
    if (RST_PAD_I) begin
      state_r   <= ST_IDLE;
      wd_r      <= 16'd0;
      gnt_o     <= 2'b00;
      done_o    <= 2'b00;
      resp_o    <= 32'd0;
      err_o     <= 5'd0;
      new_cmd_o <= 1'b0;
      arg_o     <= 32'd0;
      cmd_set_o <= 14'd0;
      int_rst_o <= 1'b0;
`ifdef SD_CMD_ARB_RR_EN
      ptr_r     <= 1'b0;
`endif
    end else begin
      done_o <= 2'b00;
      if (tmo_s) begin
        err_o     <= 5'b00001;
        resp_o    <= 32'd0;
        new_cmd_o <= 1'b0;
        int_rst_o <= 1'b1;
        done_o    <= gnt_o;
        state_r   <= ST_CLEAR;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (a_req | b_req) begin
              state_r   <= ST_ISSUE;
              wd_r      <= 16'd0;
              new_cmd_o <= 1'b1;
              if (win_b_s) begin
                gnt_o     <= 2'b10;
                arg_o     <= b_arg;
                cmd_set_o <= b_cmd;
              end else begin
                gnt_o     <= 2'b01;
                arg_o     <= a_arg;
                cmd_set_o <= a_cmd;
              end
`ifdef SD_CMD_ARB_RR_EN
              ptr_r <= ~win_b_s;
`endif
            end
          end
          ST_ISSUE: begin
            wd_r <= wd_r + 16'd1;
            if (cicmd_i) begin
              new_cmd_o <= 1'b0;
              state_r   <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            wd_r <= wd_r + 16'd1;
            if (fin_s) begin
              resp_o    <= resp_i;
              err_o     <= err_int_i;
              int_rst_o <= 1'b1;
              done_o    <= gnt_o;
              state_r   <= ST_CLEAR;
            end
          end
          ST_CLEAR: begin
            int_rst_o <= 1'b0;
            if (!fin_s) begin
              gnt_o   <= 2'b00;
              state_r <= ST_IDLE;
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            gnt_o     <= 2'b00;
            new_cmd_o <= 1'b0;
            int_rst_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Self-checking bench for sd_cmd_arbiter: completions are predicted into a scoreboard
// queue and compared when done_o pulses; scenario tasks check grant/issue timing inline.
module tb_sd_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [31:0] a_arg = 32'd0, b_arg = 32'd0;
  logic [13:0] a_cmd = 14'd0, b_cmd = 14'd0;
  logic [1:0]  gnt_o, done_o;
  logic [31:0] resp_o, arg_o;
  logic [4:0]  err_o;
  logic        new_cmd_o, int_rst_o;
  logic [13:0] cmd_set_o;
  logic        cicmd_i = 1'b0, cc_i = 1'b0, ei_i = 1'b0;
  logic [4:0]  err_int_i = 5'd0;
  logic [31:0] resp_i = 32'd0;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [31:0] resp;
    logic [4:0]  err;
  } comp_t;

  comp_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sd_cmd_arbiter #(.WD_MAX(16'd16)) dut (
    .CLK_PAD_IO(clk), .RST_PAD_I(rst),
    .a_req(a_req), .a_arg(a_arg), .a_cmd(a_cmd),
    .b_req(b_req), .b_arg(b_arg), .b_cmd(b_cmd),
    .gnt_o(gnt_o), .done_o(done_o), .resp_o(resp_o), .err_o(err_o),
    .new_cmd_o(new_cmd_o), .arg_o(arg_o), .cmd_set_o(cmd_set_o), .int_rst_o(int_rst_o),
    .cicmd_i(cicmd_i), .cc_i(cc_i), .ei_i(ei_i), .err_int_i(err_int_i), .resp_i(resp_i)
  );

  // Every done_o cycle must match the oldest predicted completion
  always @(negedge clk) begin
    if (!rst && done_o !== 2'b00) begin
      comp_t exp_c;
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_done: got done_o=%b, expected no completion", done_o);
      end else begin
        exp_c = sb.pop_front();
        if ({done_o, resp_o, err_o} !== {exp_c.gnt, exp_c.resp, exp_c.err}) begin
          tests_failed++;
          $display("FAIL completion: got done=%b resp=%h err=%b, expected done=%b resp=%h err=%b",
                   done_o, resp_o, err_o, exp_c.gnt, exp_c.resp, exp_c.err);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    a_req = 1'b0; b_req = 1'b0;
    cicmd_i = 1'b0; cc_i = 1'b0; ei_i = 1'b0;
    tick; tick;
    #2 rst = 1'b0;
    tick;
  endtask

  // Drives the command master side from just after a grant through CLEAR back to IDLE
  task automatic serve_cmd(input logic [1:0] g, input logic [31:0] r, input logic [4:0] e,
                           input logic use_cc, input logic use_ei);
    cicmd_i = 1'b1;
    tick;
    cicmd_i = 1'b0;
    resp_i = r; err_int_i = e; cc_i = use_cc; ei_i = use_ei;
    sb.push_back('{gnt: g, resp: r, err: e});
    tick;
    cc_i = 1'b0; ei_i = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    #3;
    tests_run++;
    if ({gnt_o, done_o, resp_o, err_o, new_cmd_o, arg_o, cmd_set_o, int_rst_o} !== 89'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got gnt=%b done=%b resp=%h err=%b new=%b arg=%h cmd=%h irst=%b, expected all 0",
               gnt_o, done_o, resp_o, err_o, new_cmd_o, arg_o, cmd_set_o, int_rst_o);
    end
    apply_reset;
  endtask

  task automatic test_basic;
    a_req = 1'b1; a_arg = 32'h0000_01AA; a_cmd = 14'h0802;
    tick;
    tests_run++;
    if ({gnt_o, new_cmd_o, arg_o, cmd_set_o} !== {2'b01, 1'b1, 32'h0000_01AA, 14'h0802}) begin
      tests_failed++;
      $display("FAIL basic_grant: got gnt=%b new=%b arg=%h cmd=%h, expected 01 1 000001aa 0802",
               gnt_o, new_cmd_o, arg_o, cmd_set_o);
    end
    tick;
    tests_run++;
    if (new_cmd_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_new_hold: got new_cmd_o=%b, expected 1", new_cmd_o);
    end
    cicmd_i = 1'b1;
    tick;
    cicmd_i = 1'b0;
    tests_run++;
    if (new_cmd_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_new_drop: got new_cmd_o=%b, expected 0", new_cmd_o);
    end
    cc_i = 1'b1; resp_i = 32'h0000_0120; err_int_i = 5'd0;
    sb.push_back('{gnt: 2'b01, resp: 32'h0000_0120, err: 5'd0});
    tick;
    tests_run++;
    if (int_rst_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_int_rst_on: got int_rst_o=%b, expected 1", int_rst_o);
    end
    cc_i = 1'b0; a_req = 1'b0;
    tick;
    tests_run++;
    if ({int_rst_o, gnt_o, resp_o} !== {1'b0, 2'b00, 32'h0000_0120}) begin
      tests_failed++;
      $display("FAIL basic_clear: got irst=%b gnt=%b resp=%h, expected 0 00 00000120",
               int_rst_o, gnt_o, resp_o);
    end
  endtask

  task automatic test_tie;
    logic [1:0] exp_seq [3];
`ifdef SD_CMD_ARB_RR_EN
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
`else
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01;
`endif
    apply_reset;
    a_req = 1'b1; a_arg = 32'hAAAA_0000; a_cmd = 14'h0111;
    b_req = 1'b1; b_arg = 32'hBBBB_0000; b_cmd = 14'h0C22;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests_run++;
      if (gnt_o !== exp_seq[i] ||
          arg_o !== ((exp_seq[i] == 2'b01) ? 32'hAAAA_0000 : 32'hBBBB_0000)) begin
        tests_failed++;
        $display("FAIL tie_grant%0d: got gnt=%b arg=%h, expected gnt=%b", i, gnt_o, arg_o, exp_seq[i]);
      end
      serve_cmd(exp_seq[i], 32'h0000_1000 + i, 5'd0, 1'b1, 1'b0);
    end
    a_req = 1'b0; b_req = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    a_req = 1'b1; a_arg = 32'h1234_5678; a_cmd = 14'h0403;
    tick;
    serve_cmd(2'b01, 32'h0000_00B1, 5'd0, 1'b1, 1'b0);
    tests_run++;
    if ({gnt_o, new_cmd_o} !== {2'b00, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_idle_gap: got gnt=%b new=%b, expected 00 0", gnt_o, new_cmd_o);
    end
    tick;
    tests_run++;
    if ({gnt_o, new_cmd_o} !== {2'b01, 1'b1}) begin
      tests_failed++;
      $display("FAIL b2b_regrant: got gnt=%b new=%b, expected 01 1", gnt_o, new_cmd_o);
    end
    a_req = 1'b0;
    serve_cmd(2'b01, 32'h0000_00B2, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic test_watchdog;
    a_req = 1'b1; a_arg = 32'h0000_0DDD; a_cmd = 14'h0100;
    resp_i = 32'hFFFF_FFFF;
    tick;
    sb.push_back('{gnt: 2'b01, resp: 32'd0, err: 5'b00001});
    for (int i = 0; i < 15; i++) tick;
    tests_run++;
    if ({new_cmd_o, int_rst_o} !== {1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL wd_early: got new=%b irst=%b, expected 1 0", new_cmd_o, int_rst_o);
    end
    tick;
    tests_run++;
    if ({err_o, resp_o, new_cmd_o, int_rst_o} !== {5'b00001, 32'd0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL wd_fire: got err=%b resp=%h new=%b irst=%b, expected 00001 0 0 1",
               err_o, resp_o, new_cmd_o, int_rst_o);
    end
    a_req = 1'b0;
    tick;
    tests_run++;
    if ({gnt_o, int_rst_o} !== {2'b00, 1'b0}) begin
      tests_failed++;
      $display("FAIL wd_idle: got gnt=%b irst=%b, expected 00 0", gnt_o, int_rst_o);
    end
  endtask

  task automatic test_error;
    b_req = 1'b1; b_arg = 32'h0000_0C0C; b_cmd = 14'h3001;
    tick;
    tests_run++;
    if ({gnt_o, arg_o, cmd_set_o} !== {2'b10, 32'h0000_0C0C, 14'h3001}) begin
      tests_failed++;
      $display("FAIL err_grant: got gnt=%b arg=%h cmd=%h, expected 10 00000c0c 3001", gnt_o, arg_o, cmd_set_o);
    end
    b_req = 1'b0;
    serve_cmd(2'b10, 32'h0000_0077, 5'b00010, 1'b0, 1'b1);
    tests_run++;
    if ({gnt_o, err_o} !== {2'b00, 5'b00010}) begin
      tests_failed++;
      $display("FAIL err_idle: got gnt=%b err=%b, expected 00 00010", gnt_o, err_o);
    end
  endtask

  task automatic test_both_flags;
    a_req = 1'b1; a_arg = 32'h0BAD_0001; a_cmd = 14'h0205;
    tick;
    a_req = 1'b0;
    cicmd_i = 1'b1;
    tick;
    cicmd_i = 1'b0;
    cc_i = 1'b1; ei_i = 1'b1; resp_i = 32'h0000_0555; err_int_i = 5'b00100;
    sb.push_back('{gnt: 2'b01, resp: 32'h0000_0555, err: 5'b00100});
    tick;
    tick;
    tests_run++;
    if ({int_rst_o, gnt_o, arg_o, cmd_set_o} !== {1'b0, 2'b01, 32'h0BAD_0001, 14'h0205}) begin
      tests_failed++;
      $display("FAIL both_clear_hold: got irst=%b gnt=%b arg=%h cmd=%h, expected 0 01 0bad0001 0205",
               int_rst_o, gnt_o, arg_o, cmd_set_o);
    end
    cc_i = 1'b0; ei_i = 1'b0;
    tick;
    tests_run++;
    if (gnt_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL both_idle: got gnt=%b, expected 00", gnt_o);
    end
  endtask

  task automatic test_reset_mid;
    b_req = 1'b1; b_arg = 32'h0000_0E0E; b_cmd = 14'h1234;
    tick;
    cicmd_i = 1'b1;
    tick;
    cicmd_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({gnt_o, done_o, resp_o, err_o, new_cmd_o, arg_o, cmd_set_o, int_rst_o} !== 89'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: got gnt=%b resp=%h err=%b new=%b arg=%h irst=%b, expected all 0",
               gnt_o, resp_o, err_o, new_cmd_o, arg_o, int_rst_o);
    end
    tick;
    #3 rst = 1'b0;
    tick;
    tests_run++;
    if ({gnt_o, new_cmd_o, arg_o} !== {2'b10, 1'b1, 32'h0000_0E0E}) begin
      tests_failed++;
      $display("FAIL post_reset_grant: got gnt=%b new=%b arg=%h, expected 10 1 00000e0e", gnt_o, new_cmd_o, arg_o);
    end
    b_req = 1'b0;
    serve_cmd(2'b10, 32'h0000_0B0B, 5'd0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_tie;
    test_back_to_back;
    test_watchdog;
    test_error;
    test_both_flags;
    test_reset_mid;
    tick; tick;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL missing_done: got %0d outstanding completions, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sd_cmd_arbiter.md
SD_CMD_ARBITER -- requirements
Module: sd_cmd_arbiter

Interface
REQ-001 SHALL have parameter WD_MAX, default 16'd4095, arbiter watchdog limit in cycles for the ISSUE and WAIT states combined.
REQ-002 SHALL have CLK_PAD_IO  input  1  clock; all logic rising-edge.
REQ-003 SHALL have RST_PAD_I  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have a_req  input  1  requester A (host registers) command request, level; held until done.
REQ-005 SHALL have a_arg  input  32  requester A command argument.
REQ-006 SHALL have a_cmd  input  14  requester A command-set word (index[13:8], word select[7:6], CICE[4], CRCE[3], RTS[1:0]).
REQ-007 SHALL have b_req, b_arg, b_cmd  input  1/32/14  requester B (data engine auto-stop) equivalents of A.
REQ-008 SHALL have gnt_o  output  2  one-hot grant; bit0=A, bit1=B.
REQ-009 SHALL have done_o  output  2  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have resp_o  output  32  captured response word; valid from done_o until next grant.
REQ-011 SHALL have err_o  output  5  captured error flags; same validity as resp_o.
REQ-012 SHALL have new_cmd_o, arg_o, cmd_set_o  output  1/32/14  drive the command master's New_CMD, ARG_REG, CMD_SET_REG.
REQ-013 SHALL have int_rst_o  output  1  drives both the command master's ERR_INT_RST and NORMAL_INT_RST.
REQ-014 SHALL have cicmd_i, cc_i, ei_i  input  1 each  command-in-progress, command-complete and error-interrupt flags from the command master.
REQ-015 SHALL have err_int_i  input  5  and  resp_i  input  32: error register and response word from the command master.

Function
REQ-016 SHALL implement a registered FSM with states IDLE, ISSUE, WAIT and CLEAR.
REQ-017 IDLE: if any request is high, next edge SHALL set state=ISSUE, set gnt_o, load arg_o/cmd_set_o from the winner, and set new_cmd_o=1 (one-cycle latency from request to new_cmd_o).
REQ-018 Simultaneous a_req and b_req in IDLE SHALL be resolved per REQ-029/REQ-030; the loser waits, with no lost request.
REQ-019 ISSUE: new_cmd_o SHALL remain 1 until cicmd_i is sampled 1; on that edge new_cmd_o=0 and state=WAIT.
REQ-020 WAIT: on cc_i=1 or ei_i=1, next edge SHALL capture resp_i into resp_o and err_int_i into err_o, set int_rst_o=1 and pulse done_o[granted], and set state=CLEAR.
REQ-021 CLEAR: int_rst_o SHALL deassert after exactly one cycle; state SHALL return to IDLE, with gnt_o cleared, once cc_i=0 and ei_i=0.
REQ-022 arg_o and cmd_set_o SHALL be stable from grant until leaving CLEAR.
REQ-023 A 16-bit watchdog SHALL clear on grant and increment in ISSUE and WAIT; on reaching WAIT_MAX... reaching WD_MAX it SHALL force err_o=5'b00001, resp_o=0, new_cmd_o=0, int_rst_o=1, a done_o pulse and state=CLEAR.
REQ-024 Deassertion of the granted request during ISSUE or WAIT SHALL be ignored; the command runs to completion and done_o still pulses.
REQ-025 cc_i and ei_i high together SHALL be treated as a single completion, with err_o carrying err_int_i.
REQ-026 A request re-asserted in the cycle done_o pulses SHALL NOT be granted before state returns to IDLE.

Reset
REQ-027 On RST_PAD_I=1, state SHALL be IDLE and all outputs (gnt_o, done_o, resp_o, err_o, new_cmd_o, arg_o, cmd_set_o, int_rst_o), the watchdog and the priority pointer SHALL be 0, immediately and without a clock.
REQ-028 Reset mid-command SHALL abandon the command with no done_o pulse; the requester re-requests after reset.

Configuration
REQ-029 With SD_CMD_ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie the requester not granted last wins; the pointer updates on each grant and resets to favour A.
REQ-030 Without SD_CMD_ARB_RR_EN, arbitration SHALL be fixed priority, with A always winning ties.

Verification
REQ-031 a_req=1, a_arg=32'h0000_01AA, a_cmd=14'h0802 -> next cycle gnt_o=2'b01, new_cmd_o=1, arg_o=32'h0000_01AA; cicmd_i=1 drops new_cmd_o; cc_i=1 with resp_i=32'h0000_0120 -> done_o=2'b01, resp_o=32'h0000_0120, int_rst_o pulses once.
REQ-032 a_req and b_req asserted together, both held, RR enabled -> grants in order A, B, A; RR disabled -> A, A, A.
REQ-033 Granted request, cicmd_i never asserted, WD_MAX=16 -> 16 cycles after grant err_o=5'b00001, done_o pulses, state returns to IDLE.
REQ-034 ei_i=1 with err_int_i=5'b00010 in WAIT -> err_o=5'b00010, done_o pulses, no hang.
REQ-035 RST_PAD_I pulsed during WAIT -> all outputs 0 immediately, no done_o; a subsequent b_req is granted normally.
